// File: rtl/instr_encoder_pkg.sv
// Shared ISA definitions for the instruction encoder and the control unit decode.
// Holds opcode constants, field bit positions and the encoder FSM state type.
package instr_encoder_pkg;

  localparam int INSTR_W = 24;

  localparam logic [3:0] OP_R   = 4'b0110;
  localparam logic [3:0] OP_I   = 4'b0001;
  localparam logic [3:0] OP_LS  = 4'b0010;
  localparam logic [3:0] OP_SS  = 4'b0011;
  localparam logic [3:0] OP_BEQ = 4'b0100;

  localparam int OP_MSB    = 23;
  localparam int OP_LSB    = 20;
  localparam int RS_MSB    = 19;
  localparam int RS_LSB    = 16;
  localparam int RT_MSB    = 15;
  localparam int RT_LSB    = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 8;
  localparam int FUNCT_MSB = 7;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 11;
  localparam int IMM_LSB   = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } encState_t;

  function automatic logic isLegalOp(input logic [3:0] op);
    logic ok;
    case (op)
      OP_R, OP_I, OP_LS, OP_SS, OP_BEQ: ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: builds the 24-bit instruction word and flags
// whether the opcode is one the decoder recognises.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]         op,
  input  logic [3:0]         rs,
  input  logic [3:0]         rt,
  input  logic [3:0]         rd,
  input  logic [7:0]         funct,
  input  logic [11:0]        imm,
  output logic [INSTR_W-1:0] word,
  output logic               legal
);

  always_comb begin
    word                  = '0;
    legal                 = isLegalOp(op);
    word[OP_MSB:OP_LSB]   = op;
    word[RS_MSB:RS_LSB]   = rs;
    word[RT_MSB:RT_LSB]   = rt;
    // Only R-format carries rd/funct; every other format reuses those bits for imm.
    if (op == OP_R) begin
      word[RD_MSB:RD_LSB]       = rd;
      word[FUNCT_MSB:FUNCT_LSB] = funct;
    end else begin
      word[IMM_MSB:IMM_LSB] = imm;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs instruction fields and writes them sequentially to
// instruction memory through a one-entry output register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, holds with its payload stable until ready is seen.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    length,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [3:0]         in_rs,
  input  logic [3:0]         in_rt,
  input  logic [3:0]         in_rd,
  input  logic [7:0]         in_funct,
  input  logic [11:0]        in_imm,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic               err_illegal,
  output logic [3:0]         err_op,
  output logic [ADDR_W:0]    count,
  output logic [1:0]         dbgState
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  encState_t           state;
  logic [ADDR_W-1:0]   nextAddr;
  logic [ADDR_W:0]     remaining;
  logic [INSTR_W-1:0]  packedWord;
  logic                packedLegal;
  logic                accept;
  logic                wrFire;

  instr_pack uPack (
    .op    (in_op),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .funct (in_funct),
    .imm   (in_imm),
    .word  (packedWord),
    .legal (packedLegal)
  );

  assign in_ready = (state == S_LOAD) && (!wr_valid || wr_ready);
  assign accept   = in_valid && in_ready;
  assign wrFire   = wr_valid && wr_ready;
  assign busy     = (state != S_IDLE);
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      nextAddr    <= '0;
      remaining   <= '0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_op      <= '0;
      count       <= '0;
    end else begin
      done <= 1'b0;
      if (wrFire) begin
        wr_valid <= 1'b0;
        count    <= count + LEN_ONE;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            nextAddr    <= base_addr;
            remaining   <= length;
            count       <= '0;
            err_illegal <= 1'b0;
            err_op      <= '0;
            if (length == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (packedLegal) begin
              // Loading overrides the clear above when accept and write share an edge.
              wr_valid  <= 1'b1;
              wr_addr   <= nextAddr;
              wr_data   <= packedWord;
              nextAddr  <= nextAddr + ADDR_ONE;
              remaining <= remaining - LEN_ONE;
              if (remaining == LEN_ONE) state <= S_DRAIN;
            end else begin
              err_illegal <= 1'b1;
              if (!err_illegal) err_op <= in_op;
            end
          end
        end
        S_DRAIN: begin
          if (wrFire) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: drivers push expected writes into a queue,
// a negedge monitor pops and compares every write handshake.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op, in_rs, in_rt, in_rd;
  logic [7:0]  in_funct;
  logic [11:0] in_imm;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy, done, err_illegal;
  logic [3:0]  err_op;
  logic [8:0]  count;
  logic [1:0]  dbgState;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_op(err_op),
    .count(count), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [31:0] exp_q[$];
  int          fire_log[$];
  int          last_fire = -10;
  bit          zero_len = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  exp_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every write handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, wr_addr}, {24'd0, e[31:24]});
        chk("wr_data", {8'd0, wr_data}, {8'd0, e[23:0]});
      end
      last_fire = cyc;
      fire_log.push_back(cyc);
    end
    if (!reset && done && !zero_len)
      chk("done_timing", cyc, last_fire + 1);
  end

  // drivers
  task automatic start_session(input logic [7:0] base, input logic [8:0] len);
    base_addr = base;
    length    = len;
    exp_addr  = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic set_fields(input logic [3:0] op, rs, rt, rd, input logic [7:0] funct,
                            input logic [11:0] imm);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = funct; in_imm = imm;
  endtask

  task automatic send_field(input logic [3:0] op, rs, rt, rd, input logic [7:0] funct,
                            input logic [11:0] imm, input logic [23:0] exp_data,
                            input bit legal);
    int waited;
    set_fields(op, rs, rt, rd, funct, imm);
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", waited);
    end else begin
      if (legal) begin
        exp_q.push_back({exp_addr, exp_data});
        exp_addr = exp_addr + 8'd1;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [8:0] exp_count);
    int waited;
    waited = 0;
    while (!done && waited < 50) begin
      tick();
      waited++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, expected 1", waited);
    end else begin
      chk("count_at_done", {23'd0, count}, {23'd0, exp_count});
      chk("busy_during_done", {31'd0, busy}, 32'd1);
      tick();
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
    end
    chk("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int f0;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0;
    wr_ready = 1'b1; exp_addr = '0;
    set_fields(4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 12'h000);
    tick(); tick();
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {27'd0, err_illegal, err_op}, 32'd0);
    chk("rst_addr_data", {wr_addr, wr_data}, 32'd0);
    chk("rst_count", {23'd0, count}, 32'd0);
    chk("rst_state", {30'd0, dbgState}, 32'd0);
    reset = 1'b0;
    tick();

    // R-format packing
    start_session(8'h10, 9'd1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    send_field(4'b0110, 4'd1, 4'd2, 4'd3, 8'h2A, 12'hABC, 24'h61232A, 1'b1);
    wait_done(9'd1);

    // full throughput: I-format then BEQ
    fire_log.delete();
    start_session(8'h20, 9'd2);
    send_field(4'b0001, 4'd4, 4'd5, 4'hF, 8'hCC, 12'h7FF, 24'h1457FF, 1'b1);
    send_field(4'b0100, 4'd1, 4'd1, 4'hF, 8'hCC, 12'hFFE, 24'h411FFE, 1'b1);
    wait_done(9'd2);
    f0 = (fire_log.size() == 2) ? fire_log[1] - fire_log[0] : -1;
    chk("no_bubble", f0, 32'd1);

    // illegal opcodes mid-session
    start_session(8'h30, 9'd2);
    send_field(4'b0010, 4'd7, 4'd8, 4'h0, 8'h00, 12'h123, 24'h278123, 1'b1);
    send_field(4'b1111, 4'd1, 4'd1, 4'd1, 8'h11, 12'h111, 24'h000000, 1'b0);
    send_field(4'b0000, 4'd2, 4'd2, 4'd2, 8'h22, 12'h222, 24'h000000, 1'b0);
    chk("err_illegal_set", {31'd0, err_illegal}, 32'd1);
    chk("err_op_first", {28'd0, err_op}, 32'hF);
    send_field(4'b0011, 4'd9, 4'hA, 4'h5, 8'h5A, 12'h456, 24'h39A456, 1'b1);
    wait_done(9'd2);
    chk("err_op_sticky", {28'd0, err_op}, 32'hF);

    // backpressure: hold wr_ready low for 3 cycles with a second word waiting
    wr_ready = 1'b0;
    start_session(8'h40, 9'd2);
    chk("err_cleared_by_start", {27'd0, err_illegal, err_op}, 32'd0);
    send_field(4'b0110, 4'hA, 4'hB, 4'hC, 8'h55, 12'h000, 24'h6ABC55, 1'b1);
    set_fields(4'b0001, 4'd2, 4'd3, 4'h7, 8'h77, 12'h001);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_wr_valid", {31'd0, wr_valid}, 32'd1);
      chk("bp_hold", {wr_addr, wr_data}, 32'h406ABC55);
      tick();
    end
    wr_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({8'h41, 24'h123001});
    tick();
    in_valid = 1'b0;
    wait_done(9'd2);

    // address wrap
    start_session(8'hFF, 9'd2);
    send_field(4'b0100, 4'hF, 4'hE, 4'h3, 8'h33, 12'h800, 24'h4FE800, 1'b1);
    send_field(4'b0001, 4'h0, 4'h0, 4'h9, 8'h99, 12'h00F, 24'h10000F, 1'b1);
    wait_done(9'd2);

    // length 0: done in the cycle after start, no writes
    zero_len = 1'b1;
    start_session(8'h55, 9'd0);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("len0_done_drop", {31'd0, done}, 32'd0);
    chk("len0_busy_drop", {31'd0, busy}, 32'd0);
    chk("len0_count", {23'd0, count}, 32'd0);
    zero_len = 1'b0;
    tick();

    // reset with a write pending
    wr_ready = 1'b0;
    start_session(8'h60, 9'd3);
    send_field(4'b0001, 4'd1, 4'd1, 4'd0, 8'h00, 12'h0AA, 24'h1110AA, 1'b1);
    chk("pre_reset_pending", {31'd0, wr_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("post_reset_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_count", {23'd0, count}, 32'd0);
    wr_ready = 1'b1;
    tick();
    start_session(8'h80, 9'd1);
    send_field(4'b0011, 4'd1, 4'd2, 4'd0, 8'h00, 12'h345, 24'h312345, 1'b1);
    wait_done(9'd1);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
